id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, width of PC and operand/immediate data fields.
REQ-002 Parameter: CNT_W, 16, width of the saturating bubble counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst_n  input  1  reset; asynchronous and active-low.
REQ-005 enable  input  1  global pipeline advance; 0 holds all state.
REQ-006 id_flush  input  1  discard the instruction now in ID (taken branch/jump).
REQ-007 id_alu_op  input  2  control field from decode (0 add, 1 sub, 2 R-type).
REQ-008 id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  input  1 each  decode control bits.
REQ-009 id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  input  DATA_W each  ID datapath fields.
REQ-010 id_rs_addr, id_rt_addr, id_rd_addr  input  5 each  register specifiers.
REQ-011 id_funct  input  6  instruction funct field.
REQ-012 ex_* outputs  output  same widths as each id_* input above (excluding id_flush)  registered copies.
REQ-013 stall  output  1  combinational load-use hazard; holds PC and IF/ID.
REQ-014 bubble_count  output  CNT_W  number of bubbles inserted since reset.

Function
REQ-015 Hazard: hz = ex_mem_read AND ex_rt_addr != 0 AND (ex_rt_addr == id_rs_addr OR ex_rt_addr == id_rt_addr).
REQ-016 stall SHALL equal hz AND NOT id_flush, purely combinational from current inputs/state.
REQ-017 enable=0: all registers hold; stall still reflects REQ-016; bubble_count does not change.
REQ-018 enable=1, id_flush=0, hz=0: every ex_* register captures its id_* input; latency one cycle.
REQ-019 enable=1 with id_flush=1 or hz=1: load a bubble.
REQ-020 Bubble: all 1-bit control outputs 0, ex_alu_op = 0, all data/address/funct outputs 0.
REQ-021 id_flush and hz together: single bubble; stall=0 (REQ-016); bubble_count increments once.
REQ-022 bubble_count increments by 1 on each clock edge where a bubble is loaded (enable=1).
REQ-023 bubble_count saturates at 2^CNT_W-1; no wrap-around.
REQ-024 Back-to-back hazard: after one bubble, ex_mem_read=0, so hz clears; stall lasts exactly one enabled cycle per load-use pair.
REQ-025 No ex_* output combinationally depends on id_* inputs; only stall is combinational.
REQ-026 Register $0 never raises a hazard, even if ex_mem_read=1 and addresses match.

Reset
REQ-027 arst_n low SHALL immediately (no clock) force all ex_* outputs to bubble values of REQ-020 and bubble_count to 0.
REQ-028 stall SHALL be 0 while in reset (ex_mem_read=0 implies hz=0).
REQ-029 Reset asserted mid-operation discards captured state; first enabled edge after release captures normally.
REQ-030 Reset deassertion need not be synchronised inside this block.

Verification
REQ-031 Pass-through: enable=1, R-type controls (reg_dst=1, reg_write=1, alu_op=2), rs_data=0x00000005 -> next edge ex_reg_dst=1, ex_alu_op=2, ex_rs_data=0x00000005, bubble_count=0.
REQ-032 Load-use: cycle N captures lw (mem_read=1, rt=8); cycle N+1 ID has rs=8 -> stall=1, next edge ex controls all 0, bubble_count=1, then stall=0.
REQ-033 Zero register: ex lw with rt=0, id rs=0 -> stall=0, no bubble, bubble_count unchanged.
REQ-034 Simultaneous flush and hazard: lw rt=9 in EX, id rt=9, id_flush=1 -> stall=0, one bubble, bubble_count +1.
REQ-035 Hold and reset: enable=0 for 3 edges with changing id_* -> ex_* unchanged; then arst_n=0 mid-cycle -> ex_* zero and bubble_count=0 before next edge.
REQ-036 Saturation: CNT_W=2, force 5 consecutive bubbles -> bubble_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// A bubble is inserted on a flush or a load-use hazard; stall only reports hazards that were not flushed.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              id_flush,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_2_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_jump,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [5:0]        id_funct,
  output logic [1:0]        ex_alu_op,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_2_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_jump,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [5:0]        ex_funct,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic hz;
  logic bubble;

  // $0 is hardwired to zero, so a load into it can never create a dependency
  assign hz = ex_mem_read && (ex_rt_addr != 5'd0) &&
              ((ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr));
  // A flushed instruction is discarded anyway, so holding PC for it would be wasted
  assign stall  = hz && !id_flush;
  assign bubble = hz || id_flush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_alu_op    <= 2'd0;
      ex_reg_dst   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_2_reg <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_jump      <= 1'b0;
      ex_pc_plus4  <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm_ext   <= '0;
      ex_rs_addr   <= 5'd0;
      ex_rt_addr   <= 5'd0;
      ex_rd_addr   <= 5'd0;
      ex_funct     <= 6'd0;
    end else if (enable) begin
      if (bubble) begin
        ex_alu_op    <= 2'd0;
        ex_reg_dst   <= 1'b0;
        ex_branch    <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_2_reg <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_alu_src   <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_jump      <= 1'b0;
        ex_pc_plus4  <= '0;
        ex_rs_data   <= '0;
        ex_rt_data   <= '0;
        ex_imm_ext   <= '0;
        ex_rs_addr   <= 5'd0;
        ex_rt_addr   <= 5'd0;
        ex_rd_addr   <= 5'd0;
        ex_funct     <= 6'd0;
      end else begin
        ex_alu_op    <= id_alu_op;
        ex_reg_dst   <= id_reg_dst;
        ex_branch    <= id_branch;
        ex_mem_read  <= id_mem_read;
        ex_mem_2_reg <= id_mem_2_reg;
        ex_mem_write <= id_mem_write;
        ex_alu_src   <= id_alu_src;
        ex_reg_write <= id_reg_write;
        ex_jump      <= id_jump;
        ex_pc_plus4  <= id_pc_plus4;
        ex_rs_data   <= id_rs_data;
        ex_rt_data   <= id_rt_data;
        ex_imm_ext   <= id_imm_ext;
        ex_rs_addr   <= id_rs_addr;
        ex_rt_addr   <= id_rt_addr;
        ex_rd_addr   <= id_rd_addr;
        ex_funct     <= id_funct;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bubble_count <= '0;
    end else if (enable && bubble && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
